// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, colour type and a window-compare helper.
// The top module exposes these as overridable parameter defaults.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int RGB_W = 3;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb_t;

  // True when v lies in [lo, lo+len); unsigned compare on the 10-bit counter.
  function automatic logic in_window(input logic [9:0] v, input int lo, input int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Clock divider producing a one-clk strobe on the last clk of every CLK_DIV-clk pixel period.
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic srst,
  output logic tick
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_reg;
  logic [DW-1:0] div_next;

  always_comb begin
    div_next = div_reg + 1'b1;
    if (div_reg == DIV_LAST) begin
      div_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_next;
    end
  end

  assign tick = (div_reg == DIV_LAST);

endmodule

// File: rtl/vga_raster_gen.sv
// VGA raster source: h/v pixel counters, registered syncs and blanked 3-3-3 colour,
// one pixel period behind the coordinates presented to the renderer.
module vga_raster_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [3*RGB_W-1:0] rgb_in,
  output logic [9:0]         pix_x,
  output logic [9:0]         pix_y,
  output logic               pix_active,
  output logic               pix_tick,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic [RGB_W-1:0]   red,
  output logic [RGB_W-1:0]   green,
  output logic [RGB_W-1:0]   blue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic       tick;
  logic [9:0] x_reg, x_next;
  logic [9:0] y_reg, y_next;
  logic       fs_reg, fs_next;
  logic       hs_reg, hs_next;
  logic       vs_reg, vs_next;
  rgb_t       rgb_reg, rgb_next;
  logic       active;
  logic       line_end;
  logic       frame_end;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk  (clk),
    .srst (clr),
    .tick (tick)
  );

  assign active    = (x_reg < 10'(H_ACTIVE)) && (y_reg < 10'(V_ACTIVE));
  assign line_end  = (x_reg == 10'(H_TOTAL - 1));
  assign frame_end = line_end && (y_reg == 10'(V_TOTAL - 1));

  // Everything advances only on the tick, so pins hold steady for the whole pixel period.
  always_comb begin
    x_next   = x_reg;
    y_next   = y_reg;
    fs_next  = 1'b0;
    hs_next  = hs_reg;
    vs_next  = vs_reg;
    rgb_next = rgb_reg;
    if (tick) begin
      rgb_next = active ? rgb_t'(rgb_in) : '0;
      hs_next  = in_window(x_reg, H_ACTIVE + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
      vs_next  = in_window(y_reg, V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
      if (line_end) begin
        x_next = '0;
        if (frame_end) begin
          y_next  = '0;
          fs_next = 1'b1;
        end else begin
          y_next = y_reg + 10'd1;
        end
      end else begin
        x_next = x_reg + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      x_reg   <= '0;
      y_reg   <= '0;
      fs_reg  <= 1'b0;
      hs_reg  <= ~SYNC_POL;
      vs_reg  <= ~SYNC_POL;
      rgb_reg <= '0;
    end else begin
      x_reg   <= x_next;
      y_reg   <= y_next;
      fs_reg  <= fs_next;
      hs_reg  <= hs_next;
      vs_reg  <= vs_next;
      rgb_reg <= rgb_next;
    end
  end

  assign pix_x       = x_reg;
  assign pix_y       = y_reg;
  assign pix_active  = active;
  assign pix_tick    = tick;
  assign frame_start = fs_reg;
  assign hsync       = hs_reg;
  assign vsync       = vs_reg;
  assign red         = rgb_reg.r;
  assign green       = rgb_reg.g;
  assign blue        = rgb_reg.b;

endmodule

// File: tb/tb_vga_raster_gen.sv
// Directed bench for vga_raster_gen: full 800-pixel lines, vertical timing shortened to 13 lines
// so whole frames fit in a short run.
module tb_vga_raster_gen;

  localparam int CLK_DIV = 4;
  localparam int H_TOT = 800, H_ACT = 640, HS_LO = 656, HS_HI = 752;
  localparam int V_ACT = 6, VS_LO = 8, VS_HI = 10, V_TOT = 13;
  localparam int FRAME_TICKS = H_TOT * V_TOT;

  logic       tb_clk = 1'b0;
  logic       clr = 1'b1;
  logic [8:0] rgb_in;
  logic [8:0] const_rgb = 9'h1FF;
  logic       echo = 1'b0;
  logic [9:0] pix_x, pix_y;
  logic       pix_active, pix_tick, frame_start, hsync, vsync;
  logic [2:0] red, green, blue;

  vga_raster_gen #(
    .CLK_DIV (CLK_DIV), .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (3)
  ) dut (
    .clk (tb_clk), .clr (clr), .rgb_in (rgb_in),
    .pix_x (pix_x), .pix_y (pix_y), .pix_active (pix_active), .pix_tick (pix_tick),
    .frame_start (frame_start), .hsync (hsync), .vsync (vsync),
    .red (red), .green (green), .blue (blue)
  );

  always #5 tb_clk = ~tb_clk;

  // Renderer: constant colour or echo of the current x coordinate.
  assign rgb_in = echo ? pix_x[8:0] : const_rgb;

  int tests, fails;
  int cyc, n_ticks, first_tick, last_x;
  int ctr_err, tick_err, rgb_err, sync_err, fs_err, blank_nz;
  int cap639, cap640;
  logic [8:0] exp_rgb;
  logic exp_hs, exp_vs, exp_fs, prev_hs, prev_vs, just_ticked;
  int hs_fall_q[$], hs_rise_q[$], vs_fall_q[$], vs_rise_q[$], fs_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_hsync"}, int'(hsync), 1);
    check({pfx, "_vsync"}, int'(vsync), 1);
    check({pfx, "_rgb"}, int'({red, green, blue}), 0);
    check({pfx, "_pix_x"}, int'(pix_x), 0);
    check({pfx, "_pix_y"}, int'(pix_y), 0);
    check({pfx, "_pix_tick"}, int'(pix_tick), 0);
    check({pfx, "_frame_start"}, int'(frame_start), 0);
  endtask

  task automatic model_reset();
    cyc = 0; n_ticks = 0; first_tick = -1; last_x = -1;
    exp_rgb = '0; exp_hs = 1'b1; exp_vs = 1'b1; exp_fs = 1'b0;
    prev_hs = 1'b1; prev_vs = 1'b1; just_ticked = 1'b0;
    ctr_err = 0; tick_err = 0; rgb_err = 0; sync_err = 0; fs_err = 0; blank_nz = 0;
    hs_fall_q.delete(); hs_rise_q.delete(); vs_fall_q.delete(); vs_rise_q.delete(); fs_q.delete();
  endtask

  // Compare every clk against the reference raster, then step to the next negedge.
  task automatic run_to(input int end_cyc);
    int x, y;
    logic [8:0] obs_rgb;
    while (cyc < end_cyc) begin
      x = n_ticks % H_TOT;
      y = (n_ticks / H_TOT) % V_TOT;
      obs_rgb = {red, green, blue};
      if (int'(pix_x) !== x || int'(pix_y) !== y || pix_active !== (x < H_ACT && y < V_ACT))
        ctr_err++;
      if (pix_tick !== (cyc % CLK_DIV == CLK_DIV - 1)) tick_err++;
      if (pix_tick === 1'b1 && first_tick < 0) first_tick = cyc;
      if (obs_rgb !== exp_rgb) rgb_err++;
      if (exp_rgb == 9'h000 && obs_rgb !== 9'h000) blank_nz++;
      if (hsync !== exp_hs || vsync !== exp_vs) sync_err++;
      if (frame_start !== exp_fs) fs_err++;
      if (frame_start === 1'b1) fs_q.push_back(cyc);
      if (prev_hs === 1'b1 && hsync === 1'b0) hs_fall_q.push_back(cyc);
      if (prev_hs === 1'b0 && hsync === 1'b1) hs_rise_q.push_back(cyc);
      if (prev_vs === 1'b1 && vsync === 1'b0) vs_fall_q.push_back(cyc);
      if (prev_vs === 1'b0 && vsync === 1'b1) vs_rise_q.push_back(cyc);
      prev_hs = hsync;
      prev_vs = vsync;
      if (just_ticked && echo && last_x == 639) cap639 = int'(obs_rgb);
      if (just_ticked && echo && last_x == 640) cap640 = int'(obs_rgb);
      just_ticked = 1'b0;
      exp_fs = 1'b0;
      if (cyc % CLK_DIV == CLK_DIV - 1) begin
        exp_rgb = (x < H_ACT && y < V_ACT) ? (echo ? 9'(x) : const_rgb) : 9'h000;
        exp_hs = !(x >= HS_LO && x < HS_HI);
        exp_vs = !(y >= VS_LO && y < VS_HI);
        n_ticks++;
        exp_fs = (n_ticks % FRAME_TICKS == 0);
        last_x = x;
        just_ticked = 1'b1;
      end
      @(negedge tb_clk);
      cyc++;
    end
  endtask

  initial begin
    tests = 0; fails = 0; cap639 = -1; cap640 = -1;
    repeat (5) @(negedge tb_clk);
    check_reset("rst");
    clr = 1'b0;
    model_reset();

    // One full frame plus a little, constant white renderer.
    run_to(41700);
    check("first_tick", first_tick, 3);
    check("ctr_model", ctr_err, 0);
    check("tick_model", tick_err, 0);
    check("rgb_model", rgb_err, 0);
    check("blank_zero", blank_nz, 0);
    check("sync_model", sync_err, 0);
    check("fs_model", fs_err, 0);
    check("hs_fall0", hs_fall_q[0], 4 * 657);
    check("hs_low_width", hs_rise_q[0] - hs_fall_q[0], 384);
    check("hs_period", hs_fall_q[1] - hs_fall_q[0], 3200);
    check("vs_fall0", vs_fall_q[0], 8 * 3200 + 4);
    check("vs_low_width", vs_rise_q[0] - vs_fall_q[0], 6400);
    check("fs_count", fs_q.size(), 1);
    check("fs_cycle", fs_q[0], FRAME_TICKS * CLK_DIV);

    // Coordinate echo across line 0 of the second frame.
    echo = 1'b1;
    run_to(44800);
    echo = 1'b0;
    check("echo_rgb_model", rgb_err, 0);
    check("echo_pix639", cap639, 9'h07F);
    check("echo_pix640", cap640, 0);

    // Mid-frame reset on line 3, then timing must match a fresh start.
    run_to(52201);
    check("pre_mid_ctr", ctr_err, 0);
    check("pre_mid_rgb", rgb_err, 0);
    clr = 1'b1;
    @(negedge tb_clk);
    check_reset("mid");
    clr = 1'b0;
    model_reset();
    run_to(3300);
    check("mid_first_tick", first_tick, 3);
    check("mid_ctr_model", ctr_err, 0);
    check("mid_rgb_model", rgb_err, 0);
    check("mid_sync_model", sync_err, 0);
    check("mid_hs_fall0", hs_fall_q[0], 4 * 657);
    check("mid_fs_model", fs_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
